// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared ISA constants and types for the decode stage
package decode_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_ADDI  = 4'h6;
  localparam logic [3:0] OP_LD    = 4'h7;
  localparam logic [3:0] OP_ST    = 4'h8;
  localparam logic [3:0] OP_CMP   = 4'h9;
  localparam logic [3:0] OP_JR    = 4'hA;
  localparam logic [3:0] OP_BL    = 4'hB;
  localparam logic [3:0] OP_ADDPC = 4'hC;
  localparam logic [3:0] OP_SHL   = 4'hD;

  localparam int LINK_REG_DEF = 11;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_PASS_A, ALU_PASS_B
  } alu_mode_t;

  typedef struct packed {
    logic pc_we;
    logic mem_we;
    logic mem_rd;
    logic flags_we;
    logic wr_from_alu;
    logic reg_we;
  } ctrl_t;

  typedef enum logic {RUN, HAZ} state_t;

  typedef enum logic {OP1_RS1, OP1_PC} op1_sel_t;

  typedef enum logic [1:0] {OP2_RS2, OP2_IMM12, OP2_IMM20} op2_sel_t;

endpackage

// File: rtl/isa_decoder.sv
// rtl/isa_decoder.sv - combinational instruction decoder
// Layout: [23:20] opcode, [19:16] rd/rs3, [15:12] rs1, [11:8] rs2, imm12 [11:0], imm20 [19:0].
module isa_decoder
  import decode_pkg::*;
#(
  parameter int DATA_W   = 24,
  parameter int RA_W     = 4,
  parameter int LINK_REG = LINK_REG_DEF
) (
  input  logic [DATA_W-1:0] instr,
  output ctrl_t             ctrl,
  output logic [RA_W-1:0]   rs1,
  output logic [RA_W-1:0]   rs2,
  output logic [RA_W-1:0]   rs3,
  output logic [RA_W-1:0]   rd,
  output logic              use_rs1,
  output logic              use_rs2,
  output logic              use_rs3,
  output alu_mode_t         alu_mode,
  output op1_sel_t          op1_sel,
  output op2_sel_t          op2_sel,
  output logic [DATA_W-1:0] imm12,
  output logic [DATA_W-1:0] imm20
);

  logic [3:0] opc;

  assign opc   = instr[DATA_W-1 -: 4];
  assign rs3   = instr[DATA_W-5 -: RA_W];
  assign rs1   = instr[DATA_W-9 -: RA_W];
  assign rs2   = instr[DATA_W-13 -: RA_W];
  assign imm12 = {{(DATA_W-12){1'b0}}, instr[11:0]};
  assign imm20 = {{(DATA_W-20){1'b0}}, instr[19:0]};

  always_comb begin
    ctrl     = '0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    use_rs3  = 1'b0;
    rd       = rs3;
    alu_mode = ALU_ADD;
    op1_sel  = OP1_RS1;
    op2_sel  = OP2_RS2;
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL: begin
        use_rs1          = 1'b1;
        use_rs2          = 1'b1;
        ctrl.reg_we      = 1'b1;
        ctrl.wr_from_alu = 1'b1;
        ctrl.flags_we    = 1'b1;
        case (opc)
          OP_SUB:  alu_mode = ALU_SUB;
          OP_AND:  alu_mode = ALU_AND;
          OP_OR:   alu_mode = ALU_OR;
          OP_XOR:  alu_mode = ALU_XOR;
          OP_SHL:  alu_mode = ALU_SHL;
          default: alu_mode = ALU_ADD;
        endcase
      end
      OP_ADDI: begin
        use_rs1          = 1'b1;
        op2_sel          = OP2_IMM12;
        ctrl.reg_we      = 1'b1;
        ctrl.wr_from_alu = 1'b1;
        ctrl.flags_we    = 1'b1;
      end
      OP_LD: begin
        use_rs1     = 1'b1;
        op2_sel     = OP2_IMM12;
        ctrl.mem_rd = 1'b1;
        ctrl.reg_we = 1'b1;
      end
      OP_ST: begin
        use_rs1     = 1'b1;
        use_rs3     = 1'b1;
        op2_sel     = OP2_IMM12;
        ctrl.mem_we = 1'b1;
      end
      OP_CMP: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        alu_mode      = ALU_SUB;
        ctrl.flags_we = 1'b1;
      end
      OP_JR: begin
        use_rs1    = 1'b1;
        alu_mode   = ALU_PASS_A;
        ctrl.pc_we = 1'b1;
      end
      OP_BL: begin
        // Target comes from imm20; the link value is written back from pcm4.
        rd          = RA_W'(LINK_REG);
        op2_sel     = OP2_IMM20;
        alu_mode    = ALU_PASS_B;
        ctrl.pc_we  = 1'b1;
        ctrl.reg_we = 1'b1;
      end
      OP_ADDPC: begin
        op1_sel          = OP1_PC;
        op2_sel          = OP2_IMM12;
        ctrl.reg_we      = 1'b1;
        ctrl.wr_from_alu = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage_hz.sv
// rtl/decode_stage_hz.sv - hazard-aware decode stage with bypassed register file
// Feeds the ID/EX register; handles stall, flush and load-use interlock.
module decode_stage_hz
  import decode_pkg::*;
#(
  parameter int DATA_W   = 24,
  parameter int RA_W     = 4,
  parameter int LINK_REG = LINK_REG_DEF,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] instr_i,
  input  logic              instr_valid_i,
  input  logic [DATA_W-1:0] pcm4_i,
  input  logic              wb_we_i,
  input  logic [RA_W-1:0]   wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic              pc_we_o,
  output logic              mem_we_o,
  output logic              mem_rd_o,
  output logic              flags_we_o,
  output logic              wr_from_alu_o,
  output logic              reg_we_o,
  output logic [DATA_W-1:0] op1_o,
  output logic [DATA_W-1:0] op2_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [DATA_W-1:0] pcm4_o,
  output logic [RA_W-1:0]   rd_o,
  output logic [2:0]        alu_mode_o
);

  ctrl_t             dec_ctrl;
  logic [RA_W-1:0]   rs1, rs2, rs3, dec_rd;
  logic              use_rs1, use_rs2, use_rs3;
  alu_mode_t         dec_alu;
  op1_sel_t          op1_sel;
  op2_sel_t          op2_sel;
  logic [DATA_W-1:0] imm12, imm20;

  isa_decoder #(
    .DATA_W   (DATA_W),
    .RA_W     (RA_W),
    .LINK_REG (LINK_REG)
  ) u_dec (
    .instr    (instr_i),
    .ctrl     (dec_ctrl),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs3      (rs3),
    .rd       (dec_rd),
    .use_rs1  (use_rs1),
    .use_rs2  (use_rs2),
    .use_rs3  (use_rs3),
    .alu_mode (dec_alu),
    .op1_sel  (op1_sel),
    .op2_sel  (op2_sel),
    .imm12    (imm12),
    .imm20    (imm20)
  );

  logic [DATA_W-1:0] regs [2**RA_W];
  logic [DATA_W-1:0] rs1_data, rs2_data, rs3_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**RA_W; i++) regs[i] <= '0;
    end else if (wb_we_i) begin
      regs[wb_addr_i] <= wb_data_i;
    end
  end

  assign rs1_data = (wb_we_i && wb_addr_i == rs1) ? wb_data_i : regs[rs1];
  assign rs2_data = (wb_we_i && wb_addr_i == rs2) ? wb_data_i : regs[rs2];
  assign rs3_data = (wb_we_i && wb_addr_i == rs3) ? wb_data_i : regs[rs3];

  logic [DATA_W-1:0] op1_n, op2_n;

  always_comb begin
    op1_n = (op1_sel == OP1_PC) ? pcm4_i : rs1_data;
    case (op2_sel)
      OP2_IMM12: op2_n = imm12;
      OP2_IMM20: op2_n = imm20;
      default:   op2_n = rs2_data;
    endcase
  end

  ctrl_t     ex_ctrl;
  alu_mode_t ex_alu;
  state_t    state, state_n;
  logic [2:0] cnt, cnt_n;
  logic      src_match, hazard, bubble;

  assign src_match = (use_rs1 && rs1 == rd_o) || (use_rs2 && rs2 == rd_o) ||
                     (use_rs3 && rs3 == rd_o);
  assign hazard    = ex_valid_o && ex_ctrl.mem_rd && src_match && instr_valid_i;
  assign bubble    = (state == RUN && hazard) || state == HAZ;
  assign stall_o   = stall_i || (!flush_i && bubble);

  // cnt holds the bubbles still owed after the current one; the detection
  // cycle itself is the first bubble.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (stall_i) begin
      state_n = state;
    end else if (flush_i) begin
      state_n = RUN;
      cnt_n   = '0;
    end else begin
      case (state)
        RUN: begin
          if (hazard && LOAD_LAT > 1) begin
            state_n = HAZ;
            cnt_n   = 3'(LOAD_LAT - 1);
          end
        end
        HAZ: begin
          if (cnt <= 3'd1) begin
            state_n = RUN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - 3'd1;
          end
        end
        default: begin
          state_n = RUN;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_o   <= 1'b0;
      ex_ctrl      <= '0;
      ex_alu       <= ALU_ADD;
      op1_o        <= '0;
      op2_o        <= '0;
      store_data_o <= '0;
      pcm4_o       <= '0;
      rd_o         <= '0;
    end else if (stall_i) begin
      ex_valid_o <= ex_valid_o;
    end else if (flush_i || bubble) begin
      ex_valid_o <= 1'b0;
      ex_ctrl    <= '0;
    end else begin
      ex_valid_o   <= instr_valid_i;
      ex_ctrl      <= instr_valid_i ? dec_ctrl : '0;
      ex_alu       <= dec_alu;
      op1_o        <= op1_n;
      op2_o        <= op2_n;
      store_data_o <= rs3_data;
      pcm4_o       <= pcm4_i;
      rd_o         <= dec_rd;
    end
  end

  assign pc_we_o       = ex_ctrl.pc_we;
  assign mem_we_o      = ex_ctrl.mem_we;
  assign mem_rd_o      = ex_ctrl.mem_rd;
  assign flags_we_o    = ex_ctrl.flags_we;
  assign wr_from_alu_o = ex_ctrl.wr_from_alu;
  assign reg_we_o      = ex_ctrl.reg_we;
  assign alu_mode_o    = ex_alu;

endmodule

// File: tb/tb_decode_stage_hz.sv
// tb/tb_decode_stage_hz.sv - directed self-checking bench for decode_stage_hz
module tb_decode_stage_hz;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] instr_i;
  logic        instr_valid_i;
  logic [23:0] pcm4_i;
  logic        wb_we_i;
  logic [3:0]  wb_addr_i;
  logic [23:0] wb_data_i;
  logic        flush_i;
  logic        stall_i;
  logic        stall_o, ex_valid_o;
  logic        pc_we_o, mem_we_o, mem_rd_o, flags_we_o, wr_from_alu_o, reg_we_o;
  logic [23:0] op1_o, op2_o, store_data_o, pcm4_o;
  logic [3:0]  rd_o;
  logic [2:0]  alu_mode_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decode_stage_hz #(.DATA_W(24), .RA_W(4), .LINK_REG(11), .LOAD_LAT(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .pcm4_i        (pcm4_i),
    .wb_we_i       (wb_we_i),
    .wb_addr_i     (wb_addr_i),
    .wb_data_i     (wb_data_i),
    .flush_i       (flush_i),
    .stall_i       (stall_i),
    .stall_o       (stall_o),
    .ex_valid_o    (ex_valid_o),
    .pc_we_o       (pc_we_o),
    .mem_we_o      (mem_we_o),
    .mem_rd_o      (mem_rd_o),
    .flags_we_o    (flags_we_o),
    .wr_from_alu_o (wr_from_alu_o),
    .reg_we_o      (reg_we_o),
    .op1_o         (op1_o),
    .op2_o         (op2_o),
    .store_data_o  (store_data_o),
    .pcm4_o        (pcm4_o),
    .rd_o          (rd_o),
    .alu_mode_o    (alu_mode_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] enc(input logic [3:0] op, input logic [3:0] a,
                                      input logic [3:0] b, input logic [11:0] c);
    return {op, a, b, c};
  endfunction

  function automatic logic [23:0] rr(input logic [3:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, rs2, 8'h00};
  endfunction

  task automatic wb(input logic we, input logic [3:0] a, input logic [23:0] d);
    wb_we_i = we; wb_addr_i = a; wb_data_i = d;
  endtask

  initial begin
    reset = 1'b0; instr_i = '0; instr_valid_i = 1'b0; pcm4_i = 24'h000104;
    wb_we_i = 1'b0; wb_addr_i = '0; wb_data_i = '0; flush_i = 1'b0; stall_i = 1'b0;
    #2;
    chk("rst_ex_valid", ex_valid_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_op1", op1_o, 0);
    step(); step();
    #2 reset = 1'b1;

    // Preload R1=5, R2=7
    wb(1, 4'd1, 24'd5); step();
    wb(1, 4'd2, 24'd7); step();
    wb(0, 0, 0);

    // Normal ALU op: add R3,R1,R2
    instr_i = rr(4'h1, 4'd3, 4'd1, 4'd2); instr_valid_i = 1'b1;
    step();
    chk("add_op1", op1_o, 24'd5);
    chk("add_op2", op2_o, 24'd7);
    chk("add_rd", rd_o, 3);
    chk("add_reg_we", reg_we_o, 1);
    chk("add_wr_alu", wr_from_alu_o, 1);
    chk("add_valid", ex_valid_o, 1);
    chk("add_mode", alu_mode_o, 3'd0);

    // Write-first bypass: R1 <- 9 while add R6,R1,R2 reads it
    instr_i = rr(4'h1, 4'd6, 4'd1, 4'd2); wb(1, 4'd1, 24'h000009);
    step();
    chk("byp_op1", op1_o, 24'h000009);
    chk("byp_op2", op2_o, 24'd7);
    wb(0, 0, 0);

    // Load-use with LOAD_LAT=2: ld R4,[R1+0x10] then add R5,R4,R1
    instr_i = enc(4'h7, 4'd4, 4'd1, 12'h010);
    #1 chk("ld_no_stall", stall_o, 0);
    step();
    chk("ld_mem_rd", mem_rd_o, 1);
    chk("ld_op2", op2_o, 24'h000010);
    chk("ld_wr_alu", wr_from_alu_o, 0);
    instr_i = rr(4'h1, 4'd5, 4'd4, 4'd1);
    #1 chk("lu_stall_c1", stall_o, 1);
    step();
    chk("lu_bubble1", ex_valid_o, 0);
    chk("lu_bubble1_mrd", mem_rd_o, 0);
    chk("lu_stall_c2", stall_o, 1);
    step();
    chk("lu_bubble2", ex_valid_o, 0);
    chk("lu_stall_c3", stall_o, 0);
    wb(1, 4'd4, 24'h00ABCD);
    step();
    chk("lu_valid", ex_valid_o, 1);
    chk("lu_op1", op1_o, 24'h00ABCD);
    chk("lu_op2", op2_o, 24'h000009);
    chk("lu_rd", rd_o, 5);
    wb(0, 0, 0);

    // Flush in the first HAZ cycle
    instr_i = enc(4'h7, 4'd7, 4'd1, 12'h000);
    step();
    instr_i = rr(4'h1, 4'd8, 4'd7, 4'd2);
    #1 chk("fh_hazard_stall", stall_o, 1);
    step();
    flush_i = 1'b1;
    #1 chk("fh_stall_clear", stall_o, 0);
    step();
    chk("fh_bubble", ex_valid_o, 0);
    flush_i = 1'b0;
    #1 chk("fh_run_stall", stall_o, 0);
    step();
    chk("fh_after_valid", ex_valid_o, 1);
    chk("fh_after_rd", rd_o, 8);

    // Flush together with a fresh hazard
    instr_i = enc(4'h7, 4'd7, 4'd1, 12'h000);
    step();
    instr_i = rr(4'h1, 4'd8, 4'd7, 4'd2); flush_i = 1'b1;
    #1 chk("fhz_stall", stall_o, 0);
    step();
    chk("fhz_valid", ex_valid_o, 0);
    flush_i = 1'b0;

    // Backpressure: sub R10,R1,R2 in EX, then 3 stall cycles with R2 <- 0x123456
    instr_i = rr(4'h2, 4'd10, 4'd1, 4'd2);
    step();
    chk("sub_mode", alu_mode_o, 3'd1);
    instr_i = rr(4'h1, 4'd9, 4'd2, 4'd1); stall_i = 1'b1; wb(1, 4'd2, 24'h123456);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_stall", stall_o, 1);
      step();
      wb(0, 0, 0);
      chk("bp_rd_hold", rd_o, 10);
      chk("bp_op2_hold", op2_o, 24'd7);
      chk("bp_valid_hold", ex_valid_o, 1);
    end
    stall_i = 1'b0;
    #1 chk("bp_release", stall_o, 0);
    step();
    chk("bp_op1_new", op1_o, 24'h123456);
    chk("bp_rd_new", rd_o, 9);

    // Store: st R2 -> [R1+4]
    instr_i = enc(4'h8, 4'd2, 4'd1, 12'h004);
    step();
    chk("st_data", store_data_o, 24'h123456);
    chk("st_mem_we", mem_we_o, 1);
    chk("st_reg_we", reg_we_o, 0);

    // Branch-and-link
    instr_i = {4'hB, 20'h00100}; pcm4_i = 24'h000240;
    step();
    chk("bl_rd", rd_o, 11);
    chk("bl_pc_we", pc_we_o, 1);
    chk("bl_op2", op2_o, 24'h000100);
    chk("bl_pcm4", pcm4_o, 24'h000240);
    chk("bl_mode", alu_mode_o, 3'd7);

    // Reset mid-HAZ
    instr_i = enc(4'h7, 4'd11, 4'd1, 12'h000);
    step();
    instr_i = rr(4'h1, 4'd12, 4'd11, 4'd1);
    step();
    chk("rh_in_haz", stall_o, 1);
    reset = 1'b0;
    #1;
    chk("rh_valid", ex_valid_o, 0);
    chk("rh_stall", stall_o, 0);
    chk("rh_rd", rd_o, 0);
    chk("rh_op1", op1_o, 0);
    #2 reset = 1'b1;
    instr_i = rr(4'h1, 4'd3, 4'd1, 4'd2);
    #1 chk("rh_run_stall", stall_o, 0);
    step();
    chk("rh_after_valid", ex_valid_o, 1);
    chk("rh_regs_clear", op1_o, 0);
    chk("rh_regs_clear2", op2_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
